// File: rtl/gbuff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gbuff_pkg
//  Description : Shared types and constants for the global-buffer read path.
//  Revision    : 1.0 - initial release
// ============================================================================
package gbuff_pkg;

    // Depth of the output FIFO; also the cap on words held plus words in flight
    localparam int RD_FIFO_DEPTH = 4;

    // Read latency seen through the buffer: registered index plus registered data
    localparam int RD_PIPE_LAT   = 2;

    // Width of an occupancy count able to represent 0..RD_FIFO_DEPTH
    localparam int RD_CNT_BITS   = $clog2(RD_FIFO_DEPTH) + 1;

    // Reader command state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage : gbuff_pkg
`default_nettype wire

// File: rtl/gbuff_rd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gbuff_rd_fifo
//  Description : Small synchronous FIFO holding {last, data} words returned by
//                the global buffer. Push and pop in the same cycle are allowed.
//                Storage is cleared on reset so the head reads zero afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbuff_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    localparam logic [PTR_BITS-1:0] PTR_ONE   = PTR_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_DEPTH = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q,  count_d;
    logic                do_push;
    logic                do_pop;

    assign full     = (count_q == CNT_DEPTH);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer, count and storage updates; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // State registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : gbuff_rd_fifo
`default_nettype wire

// File: rtl/gbuff_reader.sv
`default_nettype none
// ============================================================================
//  Module      : gbuff_reader
//  Description : Streaming read controller for the global buffer. Walks a
//                (base, length) address range, hides the buffer's registered
//                read latency behind a valid pipe and a small FIFO, and hands
//                the words out as a valid/ready stream with a last marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbuff_reader
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 busy,
    output logic                 done,
    output logic                 buf_wr_en,
    output logic [ADDR_BITS-1:0] buf_index,
    input  logic [DATA_BITS-1:0] buf_data_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_last
);

    localparam logic [ADDR_BITS-1:0]   ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]     LEN_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [RD_CNT_BITS-1:0] CNT_ONE   = RD_CNT_BITS'(1);
    localparam logic [RD_CNT_BITS:0]   OCC_LIMIT = (RD_CNT_BITS + 1)'(RD_FIFO_DEPTH);

    rd_state_e               state_q,       state_d;
    logic [ADDR_BITS-1:0]    addr_q,        addr_d;
    logic [ADDR_BITS:0]      remaining_q,   remaining_d;
    logic [ADDR_BITS-1:0]    buf_index_q,   buf_index_d;
    logic [RD_PIPE_LAT-1:0]  pipe_vld_q,    pipe_vld_d;
    logic [RD_PIPE_LAT-1:0]  pipe_last_q,   pipe_last_d;
    logic                    done_q,        done_d;

    logic                    rd_issue;
    logic                    last_issue;
    logic [RD_CNT_BITS-1:0]  inflight;
    logic [RD_CNT_BITS:0]    occupancy;
    logic [RD_CNT_BITS-1:0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic [DATA_BITS:0]      fifo_head;
    logic                    drain_empty;

    // Count reads issued to the buffer whose data has not yet reached the FIFO
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_PIPE_LAT; i++) begin
            inflight = inflight + RD_CNT_BITS'(pipe_vld_q[i]);
        end
    end

    // Never let held plus in-flight words exceed FIFO capacity, so a capture
    // can always be absorbed even while the consumer stalls
    assign occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
    assign rd_issue    = (state_q == READ) && (occupancy < OCC_LIMIT) && !fifo_full;
    assign last_issue  = (remaining_q == LEN_ONE);
    assign fifo_pop    = !fifo_empty && m_ready;
    assign drain_empty = (pipe_vld_q == '0) &&
                         (fifo_empty || ((fifo_count == CNT_ONE) && fifo_pop));

    // Command FSM next-state, address/length counters and done pulse
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        buf_index_d = buf_index_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    state_d     = (length != '0) ? READ : DRAIN;
                end
            end
            READ: begin
                if (rd_issue) begin
                    buf_index_d = addr_q;
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid pipe tracking buffer latency; the last flag rides with each issue
    always_comb begin
        pipe_vld_d  = {pipe_vld_q[RD_PIPE_LAT-2:0],  rd_issue};
        pipe_last_d = {pipe_last_q[RD_PIPE_LAT-2:0], rd_issue && last_issue};
    end

    // Register update; a reset mid-command drops it without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            buf_index_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            buf_index_q <= buf_index_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            done_q      <= done_d;
        end
    end

    gbuff_rd_fifo #(
        .DEPTH (RD_FIFO_DEPTH),
        .WIDTH (DATA_BITS + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_vld_q[RD_PIPE_LAT-1]),
        .push_data ({pipe_last_q[RD_PIPE_LAT-1], buf_data_out}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign buf_wr_en = 1'b0;
    assign buf_index = buf_index_q;
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[DATA_BITS-1:0];
    assign m_last    = fifo_head[DATA_BITS];

endmodule : gbuff_reader
`default_nettype wire
